// File: rtl/array_3d_row_serializer.sv
// Latches one ROWS x COLS array per input handshake and streams it out one row per output beat,
// row 0 first, with valid/ready backpressure on both sides and a synchronous abort.
module array_3d_row_serializer #(
  parameter int unsigned BIT_WIDTH = 4,
  parameter int unsigned ROWS      = 8,
  parameter int unsigned COLS      = 8,
  parameter int unsigned ROW_IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BIT_WIDTH-1:0] in_array [ROWS][COLS],
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 abort,
  output logic [BIT_WIDTH-1:0] out_row [COLS],
  output logic [ROW_IDX_W-1:0] out_row_idx,
  output logic                 out_last,
  output logic                 out_valid,
  input  logic                 out_ready
);

  typedef enum logic [0:0] {StIdle, StStream} state_e;

  localparam logic [ROW_IDX_W-1:0] LastRow = ROW_IDX_W'(ROWS - 1);

  state_e               state_q, state_d;
  logic [ROW_IDX_W-1:0] row_idx_q, row_idx_d;
  logic [BIT_WIDTH-1:0] frame_q [ROWS][COLS];
  logic                 capture;

  // Abort wins over both handshakes; the frame buffer is left untouched.
  always_comb begin
    state_d   = state_q;
    row_idx_d = row_idx_q;
    capture   = 1'b0;
    if (abort) begin
      state_d   = StIdle;
      row_idx_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            capture   = 1'b1;
            row_idx_d = '0;
            state_d   = StStream;
          end
        end
        StStream: begin
          if (out_ready) begin
            if (row_idx_q == LastRow) begin
              row_idx_d = '0;
              state_d   = StIdle;
            end else begin
              row_idx_d = row_idx_q + 1'b1;
            end
          end
        end
        default: begin
          state_d   = StIdle;
          row_idx_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      row_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      row_idx_q <= row_idx_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < ROWS; r++) begin
        for (int unsigned c = 0; c < COLS; c++) begin
          frame_q[r][c] <= '0;
        end
      end
    end else if (capture) begin
      frame_q <= in_array;
    end
  end

  // Row select as a compare-mux so the index width never has to match the array bound.
  always_comb begin
    out_row = frame_q[0];
    for (int unsigned r = 1; r < ROWS; r++) begin
      if (row_idx_q == ROW_IDX_W'(r)) begin
        out_row = frame_q[r];
      end
    end
  end

  assign in_ready    = (state_q == StIdle);
  assign out_valid   = (state_q == StStream);
  assign out_row_idx = row_idx_q;
  assign out_last    = out_valid && (row_idx_q == LastRow);

endmodule

// File: tb/tb_array_3d_row_serializer.sv
// Randomized and directed checks of the row serializer against a queue-of-rows reference model,
// plus a single-row instance.
module tb_array_3d_row_serializer;

  localparam int BW   = 4;
  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int RW   = BW * COLS;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Main 8x8 instance
  logic [BW-1:0] stim [ROWS][COLS];
  logic          in_valid, in_ready, abort, out_last, out_valid, out_ready;
  logic [BW-1:0] out_row [COLS];
  logic [2:0]    out_row_idx;

  array_3d_row_serializer #(.BIT_WIDTH(BW), .ROWS(ROWS), .COLS(COLS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_array   (stim),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .abort      (abort),
    .out_row    (out_row),
    .out_row_idx(out_row_idx),
    .out_last   (out_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  // Single-row instance
  logic [BW-1:0] stim1 [1][COLS];
  logic          in_valid1, in_ready1, abort1, out_last1, out_valid1, out_ready1;
  logic [BW-1:0] out_row1 [COLS];
  logic [0:0]    out_row_idx1;

  array_3d_row_serializer #(.BIT_WIDTH(BW), .ROWS(1), .COLS(COLS)) dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_array   (stim1),
    .in_valid   (in_valid1),
    .in_ready   (in_ready1),
    .abort      (abort1),
    .out_row    (out_row1),
    .out_row_idx(out_row_idx1),
    .out_last   (out_last1),
    .out_valid  (out_valid1),
    .out_ready  (out_ready1)
  );

  logic [RW-1:0] got_row, got_row1;
  always_comb begin
    for (int c = 0; c < COLS; c++) begin
      got_row[c*BW +: BW]  = out_row[c];
      got_row1[c*BW +: BW] = out_row1[c];
    end
  end

  int errors = 0;
  int checks = 0;

  // Reference model: rows still owed to the consumer, front = row on the bus.
  logic [RW-1:0] exp_q [$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [RW-1:0] stim_row(input int r);
    logic [RW-1:0] v;
    for (int c = 0; c < COLS; c++) v[c*BW +: BW] = stim[r][c];
    return v;
  endfunction

  task automatic check_outputs();
    check_eq("in_ready", 64'(in_ready), 64'(exp_q.size() == 0));
    check_eq("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
    check_eq("out_last", 64'(out_last), 64'(exp_q.size() == 1));
    if (exp_q.size() != 0) begin
      check_eq("out_row_idx", 64'(out_row_idx), 64'(ROWS - exp_q.size()));
      check_eq("out_row", 64'(got_row), 64'(exp_q[0]));
    end
  endtask

  // Check, take one clock edge with the currently driven inputs, update the model.
  task automatic cycle();
    check_outputs();
    @(posedge clk);
    if (abort) begin
      exp_q.delete();
    end else if (exp_q.size() == 0) begin
      if (in_valid) for (int r = 0; r < ROWS; r++) exp_q.push_back(stim_row(r));
    end else if (out_ready) begin
      void'(exp_q.pop_front());
    end
    #1;
  endtask

  task automatic fill_pattern(input int kind);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        stim[r][c] = (kind == 0) ? BW'((r * 8 + c) % 16) :
                     (kind == 1) ? BW'(4'hF) : BW'($urandom);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b0;
    in_valid1 = 1'b0; abort1 = 1'b0; out_ready1 = 1'b0;
    fill_pattern(0);
    for (int c = 0; c < COLS; c++) stim1[0][c] = '0;
    #12 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset values
    check_eq("rst_row_zero", 64'(got_row), 64'd0);
    check_eq("rst_idx", 64'(out_row_idx), 64'd0);

    // Basic stream, then overwrite input one cycle after capture
    fill_pattern(0);
    in_valid = 1'b1; out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    fill_pattern(1);
    for (int i = 0; i < ROWS + 1; i++) cycle();
    check_eq("basic_back_idle", 64'(in_ready), 64'd1);

    // Backpressure with in_valid held high during STREAM
    fill_pattern(2);
    in_valid = 1'b1;
    for (int i = 0; i < 24; i++) begin
      out_ready = (i % 3 == 0);
      cycle();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    while (!in_ready) cycle();

    // Abort during row 3 beat
    fill_pattern(2);
    in_valid = 1'b1; out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    check_eq("abort_at_row3", 64'(out_row_idx), 64'd3);
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    check_eq("abort_idle", 64'(in_ready), 64'd1);
    fill_pattern(0);
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    check_eq("after_abort_row0", 64'(out_row_idx), 64'd0);
    for (int i = 0; i < ROWS; i++) cycle();

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      fill_pattern(2);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      abort     = ($urandom_range(0, 39) == 0);
      cycle();
    end
    abort = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    while (in_ready) cycle();
    for (int i = 0; i < 2; i++) cycle();

    // Asynchronous reset mid-stream
    check_eq("pre_rst_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_out_idx", 64'(out_row_idx), 64'd0);
    check_eq("rst_out_last", 64'(out_last), 64'd0);
    check_eq("rst_out_row", 64'(got_row), 64'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_outputs();

    // ROWS=1 instance: single beat with out_last
    for (int k = 0; k < 3; k++) begin
      logic [RW-1:0] exp1;
      for (int c = 0; c < COLS; c++) begin
        stim1[0][c] = BW'($urandom);
        exp1[c*BW +: BW] = stim1[0][c];
      end
      check_eq("r1_in_ready", 64'(in_ready1), 64'd1);
      in_valid1 = 1'b1; out_ready1 = 1'b0;
      @(posedge clk); #1;
      in_valid1 = 1'b0;
      for (int c = 0; c < COLS; c++) stim1[0][c] = '1;
      @(posedge clk); #1;
      check_eq("r1_valid", 64'(out_valid1), 64'd1);
      check_eq("r1_last", 64'(out_last1), 64'd1);
      check_eq("r1_idx", 64'(out_row_idx1), 64'd0);
      check_eq("r1_row", 64'(got_row1), 64'(exp1));
      out_ready1 = 1'b1;
      @(posedge clk); #1;
      out_ready1 = 1'b0;
      check_eq("r1_back_idle", 64'(in_ready1), 64'd1);
      check_eq("r1_valid_low", 64'(out_valid1), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
